// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads instr_mem and buffers {instr, pc} in a 2-entry FIFO.
// Latency: one cycle from the PC being presented on imem_addr to the entry appearing on out_*.
// Backpressure: when the FIFO is full and decode stalls, the PC and imem_addr hold.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0028,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      fifo_mem [2];
    entry_t      head;
    logic [31:0] pc;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        push;

    assign pop  = out_valid & out_ready;
    // A full FIFO may still accept a push when the head retires in the same cycle.
    assign push = fetch_en & ~redirect_valid & ((count != FULL_COUNT) | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_target & 32'hFFFF_FFFC;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{instr: imem_rdata, pc: pc};
                wr_ptr           <= ~wr_ptr;
                pc               <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign imem_addr = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? head.instr : 32'd0;
    assign out_pc    = out_valid ? head.pc : 32'd0;
    assign out_pc4   = out_valid ? (head.pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0028;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int checks = 0;
    int errors = 0;

    // Reference model: PC plus an ordered queue of {instr, pc}, at most two deep.
    logic [31:0] m_pc;
    logic [63:0] mq [$];

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc4         (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0000_0028) return 32'h0109_5020;
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    // Apply the rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit do_pop;
        bit do_push;
        if (rst) begin
            m_pc = RESET_PC;
            mq.delete();
        end else if (redirect_valid) begin
            m_pc = {redirect_target[31:2], 2'b00};
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = fetch_en && ((mq.size() < 2) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({imem_word(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
        fetch_en = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'd0;
        tick(); tick();
        checks++;
        if (imem_addr !== RESET_PC || out_valid !== 1'b0 || out_instr !== 32'd0 ||
            out_pc !== 32'd0 || out_pc4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state addr=%h valid=%b instr=%h pc=%h pc4=%h expected addr=%h and zeros",
                     imem_addr, out_valid, out_instr, out_pc, out_pc4, RESET_PC);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0109_5020 || out_pc !== 32'h28 || out_pc4 !== 32'h2C) begin
            errors++;
            $display("FAIL first_fetch valid=%b instr=%h pc=%h pc4=%h expected 1 01095020 00000028 0000002c",
                     out_valid, out_instr, out_pc, out_pc4);
        end
        tick();
        checks++;
        if (out_pc !== 32'h2C) begin
            errors++;
            $display("FAIL second_fetch pc=%h expected 0000002c", out_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr [5] = '{32'h2C, 32'h30, 32'h30, 32'h30, 32'h30};
        logic [31:0] exp_head [4] = '{32'h28, 32'h2C, 32'h30, 32'h34};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL stall_addr cycle=%0d addr=%h expected %h", i, imem_addr, exp_addr[i]);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_head[i]) begin
                errors++;
                $display("FAIL drain_order step=%0d valid=%b pc=%h expected 1 %h", i, out_valid, out_pc, exp_head[i]);
            end
            tick();
        end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] exp_pc;
        do_reset();
        tick(); tick();
        out_ready = 1'b1;
        exp_pc = 32'h28;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || imem_addr !== exp_pc + 32'd8 ||
                out_instr !== imem_word(exp_pc)) begin
                errors++;
                $display("FAIL full_pushpop step=%0d valid=%b pc=%h addr=%h instr=%h expected pc=%h addr=%h instr=%h",
                         i, out_valid, out_pc, imem_addr, out_instr, exp_pc, exp_pc + 32'd8, imem_word(exp_pc));
            end
            tick();
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_flush valid=%b addr=%h expected 0 00000100", out_valid, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== imem_word(32'h100)) begin
            errors++;
            $display("FAIL redirect_target valid=%b pc=%h instr=%h expected 1 00000100 %h",
                     out_valid, out_pc, out_instr, imem_word(32'h100));
        end
    endtask

    task automatic test_reset_redirect();
        do_reset();
        tick(); tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0200; out_ready = 1'b1;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'h28 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_redirect addr=%h valid=%b expected 00000028 0", imem_addr, out_valid);
        end
        tick(); tick();
        checks++;
        if (out_pc !== 32'h2C) begin
            errors++;
            $display("FAIL reset_over_redirect_stream pc=%h expected 0000002c", out_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (out_pc !== 32'hFFFF_FFFC || out_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_last pc=%h pc4=%h expected fffffffc 00000000", out_pc, out_pc4);
        end
        tick();
        checks++;
        if (out_pc !== 32'h0 || out_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_zero pc=%h pc4=%h expected 00000000 00000004", out_pc, out_pc4);
        end
    endtask

    task automatic test_fetch_en();
        do_reset();
        out_ready = 1'b1;
        tick(); tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h30 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold cycle=%0d addr=%h valid=%b expected 00000030 0", i, imem_addr, out_valid);
            end
        end
        fetch_en = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h30) begin
            errors++;
            $display("FAIL fetch_resume valid=%b pc=%h expected 1 00000030", out_valid, out_pc);
        end
    endtask

    task automatic test_random();
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(99) == 0);
            redirect_valid  = ($urandom_range(19) == 0);
            redirect_target = $urandom;
            fetch_en        = ($urandom_range(4) != 0);
            out_ready       = ($urandom_range(9) < 6);
            tick();
            e_valid = (mq.size() != 0);
            e_instr = e_valid ? mq[0][63:32] : 32'd0;
            e_pc    = e_valid ? mq[0][31:0] : 32'd0;
            e_pc4   = e_valid ? mq[0][31:0] + 32'd4 : 32'd0;
            checks++;
            if (imem_addr !== m_pc || out_valid !== e_valid || out_instr !== e_instr ||
                out_pc !== e_pc || out_pc4 !== e_pc4) begin
                errors++;
                $display("FAIL random cycle=%0d got addr=%h v=%b i=%h pc=%h pc4=%h expected addr=%h v=%b i=%h pc=%h pc4=%h",
                         i, imem_addr, out_valid, out_instr, out_pc, out_pc4, m_pc, e_valid, e_instr, e_pc, e_pc4);
            end
        end
    endtask

    initial begin
        m_pc = RESET_PC;
        test_reset();
        test_backpressure();
        test_full_pushpop();
        test_redirect();
        test_reset_redirect();
        test_wrap();
        test_fetch_en();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the `cpu` datapath. It owns the program counter, drives the instruction memory address, and buffers fetched instructions with their PCs in a 2-entry FIFO. Entries go to decode over a valid/ready handshake. Branch and jump redirects from the datapath flush the buffer and reload the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0028: PC loaded on reset. Word 10 of `instr_mem`.
- `DEPTH`, default 2: FIFO entries. Fixed at 2. Other values are unsupported.

Ports:
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `fetch_en`  in  1  When 0: no push, PC holds. Pops still allowed.
- `imem_addr`  out  32  Byte address to `instr_mem`. Equals the PC register, combinationally.
- `imem_rdata`  in  32  Instruction word from `instr_mem`. Combinational read, valid in the same cycle.
- `redirect_valid`  in  1  One-cycle pulse: taken branch or jump.
- `redirect_target`  in  32  New PC. Bits [1:0] are ignored (forced to 0).
- `out_valid`  out  1  FIFO head holds an instruction. Equals count != 0.
- `out_ready`  in  1  Decode accepts the head this cycle.
- `out_instr`  out  32  Head instruction. 0 when FIFO is empty.
- `out_pc`  out  32  PC of the head instruction. 0 when FIFO is empty.
- `out_pc4`  out  32  out_pc + 4, modulo 2^32. 0 when FIFO is empty.

## Operation
- State:
  - `pc[31:0]`
  - FIFO storage: 2 × {instr[31:0], pc[31:0]}
  - `wr_ptr`, `rd_ptr` (1 bit each, wrap modulo 2)
  - `count[1:0]` (0..2)
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - A push writes {imem_rdata, pc} at wr_ptr, advances wr_ptr, and sets pc <= pc + 4.
- Priority, highest first, evaluated every edge:
  1. rst: pc <= RESET_PC; count, wr_ptr, rd_ptr <= 0.
  2. redirect_valid: pc <= {redirect_target[31:2], 2'b00}; count, wr_ptr, rd_ptr <= 0. No push occurs. A coincident pop is accepted by decode but has no additional effect, because the flush discards the FIFO anyway.
  3. Normal operation: count <= count + push − pop.
- Full FIFO (count == 2):
  - With no pop: no push, PC holds, and imem_addr stays stable.
  - With a pop: push and pop both occur and count stays at 2.
- Empty FIFO (count == 0): out_valid = 0, so a pop cannot happen. out_ready is don't-care.
- PC wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No flag is raised.
- fetch_en low: no push and PC holds. Existing entries still drain.
- No internal hazard detection. Redirect timing is entirely the datapath's responsibility.

## Timing
- Reset values, while rst is high and on the first cycle after its release:
  - imem_addr = RESET_PC
  - out_valid = 0
  - out_instr, out_pc, out_pc4 = 0
- Fetch latency: the instruction at address A is pushed on the edge ending the cycle where pc == A. It is visible on out_* in the following cycle, so latency is 1 cycle.
- After rst falls (cycle 0): out_valid = 1 in cycle 1, with out_pc = RESET_PC.
- Throughput: with out_ready held at 1, one instruction per cycle.
- Redirect at cycle N:
  - Cycle N+1: out_valid = 0 and imem_addr = target.
  - Cycle N+2: first target instruction is valid.
- Reset mid-stream overrides a pending redirect and any push or pop in the same cycle.
- All outputs depend only on registered state, except imem_addr, which is pc itself. No combinational path from out_ready or redirect_valid to any output.

## Test plan
- Reset release with imem[0x28] = 32'h0109_5020 and out_ready = 1:
  - Cycle 1: out_valid = 1, out_instr = 32'h0109_5020, out_pc = 32'h28, out_pc4 = 32'h2C.
  - Cycle 2: out_pc = 32'h2C.
- Backpressure: out_ready = 0 for 5 cycles after reset.
  - count reaches 2; imem_addr holds at 32'h30.
  - Raise out_ready: entries drain in order 0x28, 0x2C, 0x30 with no gap or duplicate.
- Simultaneous push/pop while full: count stays 2 and one instruction retires per cycle. PCs increase by 4 per accepted entry.
- Redirect pulse with target 32'h0000_0103 while 2 entries are buffered:
  - Next cycle: out_valid = 0 and imem_addr = 32'h100.
  - Cycle after: out_pc = 32'h100.
- Reset asserted in the same cycle as redirect_valid with a full FIFO: pc = 32'h28, out_valid = 0. The redirect target is never fetched.
- Boundary and hold cases:
  - Start from redirect target 32'hFFFF_FFFC: the next out_pc is 32'h0 and its out_pc4 is 32'h4.
  - fetch_en = 0 for 3 cycles: PC frozen and no new entries.
